imem_program_loader: RTL and testbench

- Write-side counterpart to the core's instruction fetch path.
- Receives a byte stream over a valid/ready handshake and packs it into 32-bit big-endian instruction words.
- Writes the words into instruction memory at consecutive word addresses.
- Holds the core (core_hold) until the image is fully loaded. The core fetches by word-indexed PC (PC+1 per instruction), so imem_addr is a word index.

---
 rtl/imem_program_loader.sv | 165 ++++++++++++++++
 tb/tb_imem_program_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// Streams a length-prefixed byte image into instruction memory as big-endian 32-bit words.
// Defining IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte to the stream.
module imem_program_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR_HI  = 3'd1,
        HDR_LO  = 3'd2,
        PAYLOAD = 3'd3,
        DONE    = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK     = 3'd6,
`endif
        ERR     = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [16:0]       CAPACITY = 17'((1 << ADDR_W) - BASE_ADDR);

    state_t      state;
    logic [15:0] count_n;
    logic [23:0] asm_q;
    logic [1:0]  byte_idx;
    logic        accept;
    logic [15:0] header_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  checksum;
`endif

    assign accept   = in_valid && in_ready;
    assign header_n = {count_n[15:8], in_data};

    always_comb begin
        in_ready = 1'b0;
        case (state)
            HDR_HI, HDR_LO, PAYLOAD: in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:                     in_ready = 1'b1;
`endif
            default:                 in_ready = 1'b0;
        endcase
    end

    // The finishing transition lands in CHK when checksums are enabled, otherwise straight in DONE.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            core_hold    <= 1'b1;
            imem_we      <= 1'b0;
            imem_addr    <= BASE;
            imem_wdata   <= 32'd0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
            byte_idx     <= 2'd0;
            count_n      <= 16'd0;
            asm_q        <= 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            checksum     <= 8'd0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= HDR_HI;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        core_hold    <= 1'b1;
                        words_loaded <= 16'd0;
                        byte_idx     <= 2'd0;
                        imem_addr    <= BASE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        checksum     <= 8'd0;
`endif
                    end
                end
                HDR_HI: begin
                    if (accept) begin
                        count_n[15:8] <= in_data;
                        state         <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        count_n[7:0] <= in_data;
                        if (header_n == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state     <= CHK;
`else
                            state     <= DONE;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
`endif
                        end else if ({1'b0, header_n} > CAPACITY) begin
                            state <= ERR;
                            error <= 1'b1;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        checksum <= checksum ^ in_data;
`endif
                        if (byte_idx == 2'd3) begin
                            imem_we      <= 1'b1;
                            imem_wdata   <= {asm_q, in_data};
                            imem_addr    <= BASE + ADDR_W'(words_loaded);
                            words_loaded <= words_loaded + 16'd1;
                            byte_idx     <= 2'd0;
                            if (words_loaded + 16'd1 == count_n) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state     <= CHK;
`else
                                state     <= DONE;
                                done      <= 1'b1;
                                core_hold <= 1'b0;
`endif
                            end
                        end else begin
                            asm_q    <= {asm_q[15:0], in_data};
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                CHK: begin
                    if (accept) begin
                        if (in_data == checksum) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            core_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader (ADDR_W=4 so the overflow and full-capacity cases are cheap).
module tb_imem_program_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [3:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int          vectors;
    int          miscompares;
    int          we_total;
    logic [3:0]  log_addr[128];
    logic [31:0] log_data[128];

    imem_program_loader #(.ADDR_W(4), .BASE_ADDR(0)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_hold(core_hold),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Strobes last exactly one cycle, so one negedge sample per write.
    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            if (we_total < 128) begin
                log_addr[we_total] = imem_addr;
                log_data[we_total] = imem_wdata;
            end
            we_total = we_total + 1;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit sent;
        sent = 1'b0;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 20 && !sent; i++) begin
            if (in_ready === 1'b1) begin
                @(posedge clock);
                sent = 1'b1;
            end else begin
                @(negedge clock);
            end
        end
        if (!sent) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL handshake_timeout: in_ready stayed %b, required 1", in_ready);
        end
    endtask

    task automatic apply_stimulus(input byte_q_t q, input bit gaps);
        foreach (q[i]) begin
            send_byte(q[i]);
            if (gaps) begin
                @(negedge clock);
                in_valid = 1'b0;
                in_data  = 8'hAA;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clock);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
    endtask

    task automatic settle(input int n);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_output({tag, "_core_hold"}, 32'(core_hold), 32'd1);
        check_output({tag, "_imem_we"}, 32'(imem_we), 32'd0);
        check_output({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
        check_output({tag, "_imem_wdata"}, imem_wdata, 32'd0);
        check_output({tag, "_done"}, 32'(done), 32'd0);
        check_output({tag, "_error"}, 32'(error), 32'd0);
        check_output({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic check_basic_load(input string tag, input int base);
        check_output({tag, "_we_count"}, 32'(we_total - base), 32'd2);
        check_output({tag, "_addr0"}, 32'(log_addr[base]), 32'd0);
        check_output({tag, "_data0"}, log_data[base], 32'h38200005);
        check_output({tag, "_addr1"}, 32'(log_addr[base+1]), 32'd1);
        check_output({tag, "_data1"}, log_data[base+1], 32'h38400007);
        check_output({tag, "_words_loaded"}, 32'(words_loaded), 32'd2);
        check_output({tag, "_done"}, 32'(done), 32'd1);
        check_output({tag, "_core_hold"}, 32'(core_hold), 32'd0);
        check_output({tag, "_error"}, 32'(error), 32'd0);
        check_output({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    endtask

    byte_q_t basic;
    byte_q_t q;
    int      base;
    logic [7:0]  xsum;
    logic [31:0] word;

    initial begin
        vectors     = 0;
        miscompares = 0;
        we_total    = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        basic = '{8'h00, 8'h02, 8'h38, 8'h20, 8'h00, 8'h05, 8'h38, 8'h40, 8'h00, 8'h07};
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        check_reset_values("reset");

        // Basic load with in_valid held high.
        base = we_total;
        pulse_start();
        check_output("start_in_ready", 32'(in_ready), 32'd1);
        q = basic;
`ifdef IMEM_LOADER_CHECKSUM_EN
        q.push_back(8'h62);
`endif
        apply_stimulus(q, 1'b0);
        settle(2);
        check_basic_load("basic", base);

        // Same image with a gap after every byte.
        base = we_total;
        pulse_start();
        check_output("restart_done", 32'(done), 32'd0);
        check_output("restart_core_hold", 32'(core_hold), 32'd1);
        check_output("restart_words_loaded", 32'(words_loaded), 32'd0);
        apply_stimulus(q, 1'b1);
        settle(3);
        check_basic_load("gaps", base);

        // Zero-length image.
        base = we_total;
        pulse_start();
        q = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        q.push_back(8'h00);
`endif
        apply_stimulus(q, 1'b0);
        @(negedge clock);
        in_valid = 1'b0;
        check_output("zero_done", 32'(done), 32'd1);
        check_output("zero_words_loaded", 32'(words_loaded), 32'd0);
        settle(1);
        check_output("zero_we_count", 32'(we_total - base), 32'd0);

        // Overflow: 17 words into a 16-word memory.
        base = we_total;
        pulse_start();
        apply_stimulus('{8'h00, 8'h11}, 1'b0);
        settle(1);
        check_output("ovf_error", 32'(error), 32'd1);
        check_output("ovf_core_hold", 32'(core_hold), 32'd1);
        check_output("ovf_in_ready", 32'(in_ready), 32'd0);
        check_output("ovf_done", 32'(done), 32'd0);
        check_output("ovf_we_count", 32'(we_total - base), 32'd0);
        pulse_start();
        check_output("ovf_restart_error", 32'(error), 32'd0);
        check_output("ovf_restart_in_ready", 32'(in_ready), 32'd1);

        // Exactly full capacity (16 words) from the HDR_HI state left above.
        base = we_total;
        xsum = 8'h00;
        q = '{8'h00, 8'h10};
        for (int i = 0; i < 16; i++) begin
            word = {8'(i), 8'h5A, 8'hA5, 8'(255 - i)};
            for (int k = 3; k >= 0; k--) begin
                q.push_back(word[k*8 +: 8]);
                xsum = xsum ^ word[k*8 +: 8];
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        q.push_back(xsum);
`endif
        apply_stimulus(q, 1'b0);
        settle(2);
        check_output("full_we_count", 32'(we_total - base), 32'd16);
        check_output("full_addr0", 32'(log_addr[base]), 32'd0);
        check_output("full_data0", log_data[base], 32'h005AA5FF);
        check_output("full_addr15", 32'(log_addr[base+15]), 32'd15);
        check_output("full_data15", log_data[base+15], 32'h0F5AA5F0);
        check_output("full_words_loaded", 32'(words_loaded), 32'd16);
        check_output("full_done", 32'(done), 32'd1);
        check_output("full_error", 32'(error), 32'd0);

        // Reset after six bytes: word 0 lands, word 1 never does.
        base = we_total;
        pulse_start();
        apply_stimulus('{8'h00, 8'h02, 8'h38, 8'h20, 8'h00, 8'h05}, 1'b0);
        @(negedge clock);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(negedge clock);
        reset_n  = 1'b1;
        check_reset_values("midreset");
        settle(2);
        check_output("midreset_we_count", 32'(we_total - base), 32'd1);
        check_output("midreset_idle_in_ready", 32'(in_ready), 32'd0);
        base = we_total;
        pulse_start();
        q = basic;
`ifdef IMEM_LOADER_CHECKSUM_EN
        q.push_back(8'h62);
`endif
        apply_stimulus(q, 1'b0);
        settle(2);
        check_basic_load("reload", base);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum byte: both words still written, load flagged as failed.
        base = we_total;
        pulse_start();
        q = basic;
        q.push_back(8'h63);
        apply_stimulus(q, 1'b0);
        settle(2);
        check_output("badsum_error", 32'(error), 32'd1);
        check_output("badsum_core_hold", 32'(core_hold), 32'd1);
        check_output("badsum_done", 32'(done), 32'd0);
        check_output("badsum_we_count", 32'(we_total - base), 32'd2);
        check_output("badsum_data1", log_data[base+1], 32'h38400007);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
